// File: rtl/escaner_display_7seg_if.sv
// rtl/escaner_display_7seg_if.sv - value/load inputs and scan outputs of the 7-segment digit scanner
interface escaner_display_7seg_if #(
  parameter int N_DIGITOS = 4
);
  localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

  logic [4*N_DIGITOS-1:0] i_Valor;
  logic                   i_Load;
  logic                   i_Supr_Ceros;
  logic [3:0]             o_Bits;
  logic [N_DIGITOS-1:0]   o_Anodos;
  logic [IDX_W-1:0]       o_Digito;
  logic                   o_Ocupado;
  logic                   o_Fin_Trama;

  modport master (
    output i_Valor, i_Load, i_Supr_Ceros,
    input  o_Bits, o_Anodos, o_Digito, o_Ocupado, o_Fin_Trama
  );

  modport slave (
    input  i_Valor, i_Load, i_Supr_Ceros,
    output o_Bits, o_Anodos, o_Digito, o_Ocupado, o_Fin_Trama
  );
endinterface

// File: rtl/escaner_display_7seg.sv
// rtl/escaner_display_7seg.sv - multiplexed N-digit scanner feeding a hex-to-7-segment decoder
module escaner_display_7seg #(
  parameter int N_DIGITOS    = 4,
  parameter int DIV_REFRESCO = 50000,
  parameter bit ANODO_BAJO   = 1'b1
) (
  input logic                    i_Clk,
  input logic                    i_Rst_n,
  escaner_display_7seg_if.slave  bus
);
  localparam int CNT_W = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
  localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DIV_REFRESCO - 1);
  localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(N_DIGITOS - 1);
  localparam logic [N_DIGITOS-1:0] UNO     = N_DIGITOS'(1);

  logic [CNT_W-1:0]       cuenta;
  logic [IDX_W-1:0]       indice;
  logic [4*N_DIGITOS-1:0] pantalla;
  logic [4*N_DIGITOS-1:0] reserva;
  logic                   pendiente;
  logic                   fin_trama;
  logic                   tick;
  logic                   frontera;

  assign tick     = (cuenta == CNT_MAX);
  assign frontera = tick && (indice == IDX_MAX);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cuenta    <= '0;
      indice    <= '0;
      pantalla  <= '0;
      reserva   <= '0;
      pendiente <= 1'b0;
      fin_trama <= 1'b0;
    end else begin
      cuenta    <= tick ? '0 : cuenta + 1'b1;
      fin_trama <= frontera;
      if (tick) begin
        indice <= frontera ? '0 : indice + 1'b1;
      end
      // The displayed value only changes on the frame boundary, so a frame is never torn.
      if (frontera) begin
        if (bus.i_Load) begin
          pantalla <= bus.i_Valor;
        end else if (pendiente) begin
          pantalla <= reserva;
        end
        pendiente <= 1'b0;
      end else if (bus.i_Load) begin
        reserva   <= bus.i_Valor;
        pendiente <= 1'b1;
      end
    end
  end

  // cero_alto[k] is set when nibbles k..N-1 of the displayed value are all zero.
  logic [N_DIGITOS-1:0] cero_alto;
  logic                 apagado;
  logic [N_DIGITOS-1:0] activos;

  always_comb begin
    cero_alto = '0;
    cero_alto[N_DIGITOS-1] = (pantalla[4*(N_DIGITOS-1) +: 4] == 4'h0);
    for (int k = N_DIGITOS - 2; k >= 0; k--) begin
      cero_alto[k] = cero_alto[k+1] && (pantalla[4*k +: 4] == 4'h0);
    end
    apagado = bus.i_Supr_Ceros && (indice != '0) && cero_alto[indice];
    activos = apagado ? '0 : (UNO << indice);
  end

  assign bus.o_Bits      = pantalla[4*indice +: 4];
  assign bus.o_Anodos    = ANODO_BAJO ? ~activos : activos;
  assign bus.o_Digito    = indice;
  assign bus.o_Ocupado   = pendiente;
  assign bus.o_Fin_Trama = fin_trama;
endmodule

// File: tb/tb_escaner_display_7seg.sv
// tb/tb_escaner_display_7seg.sv - randomized self-checking bench for the 7-segment digit scanner
module tb_escaner_display_7seg;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FR  = N * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  escaner_display_7seg_if #(.N_DIGITOS(N)) bus ();

  escaner_display_7seg #(
    .N_DIGITOS(N),
    .DIV_REFRESCO(DIV),
    .ANODO_BAJO(1'b1)
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset release, shown value, staged value.
  int          t;
  logic [15:0] m_disp;
  logic [15:0] m_stage;
  bit          m_pend;
  bit          m_fin;
  logic        m_supr;

  logic [11:0] obs;
  assign obs = {bus.o_Bits, bus.o_Anodos, bus.o_Digito, bus.o_Ocupado, bus.o_Fin_Trama};

  localparam logic [11:0] RESET_VEC = {4'h0, 4'hE, 2'd0, 1'b0, 1'b0};

  function automatic logic [11:0] exp_vec();
    int   idx;
    logic [3:0] bits;
    logic [3:0] an;
    bit   lit;
    idx  = (t / DIV) % N;
    bits = 4'((m_disp >> (4 * idx)) & 16'hF);
    lit  = !(m_supr && idx >= 1 && ((m_disp >> (4 * idx)) == 16'h0));
    an   = lit ? (4'hF & ~(4'b1 << idx)) : 4'hF;
    return {bits, an, 2'(idx), m_pend, m_fin};
  endfunction

  task automatic model_reset();
    t = 0; m_disp = '0; m_stage = '0; m_pend = 0; m_fin = 0;
  endtask

  // Called from a negedge: apply inputs, take one rising edge, advance the model, return at the next negedge.
  task automatic step(input logic ld, input logic [15:0] v, input logic sz);
    bit boundary;
    bus.i_Load = ld; bus.i_Valor = v; bus.i_Supr_Ceros = sz;
    m_supr = sz;
    @(posedge clk);
    boundary = (t % FR) == FR - 1;
    if (boundary) begin
      if (ld) m_disp = v;
      else if (m_pend) m_disp = m_stage;
      m_pend = 0;
    end else if (ld) begin
      m_stage = v;
      m_pend  = 1;
    end
    m_fin = boundary;
    t++;
    @(negedge clk);
    bus.i_Load = 1'b0;
  endtask

  task automatic align(input int phase);
    while ((t % FR) != phase) step(1'b0, 16'h0, m_supr);
  endtask

  task automatic test_reset();
    bus.i_Load = 0; bus.i_Valor = '0; bus.i_Supr_Ceros = 0; m_supr = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset obs=%h exp=%h", obs, RESET_VEC);
    end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3 * FR; i++) begin
      step(1'b0, 16'hFFFF, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL idle t=%0d obs=%h exp=%h", t, obs, exp_vec());
      end
    end
  endtask

  task automatic test_load_mid();
    align(5);
    step(1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 2 * FR; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL load_mid t=%0d obs=%h exp=%h", t, obs, exp_vec());
      end
      step(1'b0, 16'h0, 1'b0);
    end
  endtask

  task automatic test_newest_wins();
    align(2);
    step(1'b1, 16'hAAAA, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h5F0C, 1'b0);
    for (int i = 0; i < 2 * FR; i++) begin
      checks++;
      if (obs !== exp_vec() || bus.o_Bits === 4'hA) begin
        errors++;
        $display("FAIL newest_wins t=%0d obs=%h exp=%h", t, obs, exp_vec());
      end
      step(1'b0, 16'h0, 1'b0);
    end
  endtask

  task automatic test_load_boundary();
    align(FR - 1);
    step(1'b1, 16'h00B7, 1'b0);
    for (int i = 0; i < FR + 2; i++) begin
      checks++;
      if (obs !== exp_vec() || bus.o_Ocupado !== 1'b0) begin
        errors++;
        $display("FAIL load_boundary t=%0d obs=%h exp=%h", t, obs, exp_vec());
      end
      step(1'b0, 16'h0, 1'b0);
    end
  endtask

  task automatic test_blanking();
    logic [15:0] vals [2];
    vals[0] = 16'h0007;
    vals[1] = 16'h0000;
    for (int j = 0; j < 2; j++) begin
      align(3);
      step(1'b1, vals[j], 1'b1);
      for (int i = 0; i < 2 * FR; i++) begin
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL blanking v=%h t=%0d obs=%h exp=%h", vals[j], t, obs, exp_vec());
        end
        step(1'b0, 16'h0, 1'b1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 5) == 0), 16'($urandom), 1'($urandom));
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random t=%0d obs=%h exp=%h", t, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_pending();
    align(6);
    step(1'b1, 16'h9876, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    checks++;
    if (bus.o_Ocupado !== 1'b1) begin
      errors++;
      $display("FAIL reset_pending_armed ocupado=%b exp=1", bus.o_Ocupado);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_pending_async obs=%h exp=%h", obs, RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 2 * FR; i++) begin
      step(1'b0, 16'h0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL reset_pending_after t=%0d obs=%h exp=%h", t, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_load_mid();
    test_newest_wins();
    test_load_boundary();
    test_blanking();
    test_random();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
